// File: rtl/adder_seq_nbit.sv
// Multi-cycle adder/subtractor. It adds CHUNK_WIDTH bits per clock, least
// significant chunk first, and keeps the carry in a register between chunks.
// Subtract is computed as a + ~b + !borrow_in. The result registers change
// only on the edge that finishes an operation.
module adder_seq_nbit #(
    parameter int BIT_WIDTH   = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 sub_i,
    input  logic [BIT_WIDTH-1:0] a_i,
    input  logic [BIT_WIDTH-1:0] b_i,
    input  logic                 carry_in_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BIT_WIDTH-1:0] sum_o,
    output logic                 carry_out_o,
    output logic                 overflow_o
);

    localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Operands shift right one chunk per step, so the active chunk is always
    // in the low bits. This avoids a variable-index mux.
    logic [BIT_WIDTH-1:0]   a_q, a_d;
    logic [BIT_WIDTH-1:0]   b_q, b_d;
    logic                   carry_q, carry_d;
    // The partial sum fills from the top. After NUM_CHUNKS steps, chunk 0
    // has reached bit 0.
    logic [BIT_WIDTH-1:0]   psum_q, psum_d;
    logic [BIT_WIDTH-1:0]   sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    logic [CHUNK_WIDTH-1:0] a_ch, b_ch, s_ch;
    logic [CHUNK_WIDTH:0]   add_w;
    logic                   c_ch;
    logic                   msb_cin;
    logic [BIT_WIDTH-1:0]   psum_nx;

    // One chunk of carry chain: this is the only wide arithmetic per cycle.
    always_comb begin
        a_ch    = a_q[CHUNK_WIDTH-1:0];
        b_ch    = b_q[CHUNK_WIDTH-1:0];
        add_w   = (CHUNK_WIDTH+1)'(a_ch) + (CHUNK_WIDTH+1)'(b_ch)
                + (CHUNK_WIDTH+1)'(carry_q);
        s_ch    = add_w[CHUNK_WIDTH-1:0];
        c_ch    = add_w[CHUNK_WIDTH];
        // Carry into the top bit of this chunk. It is only used on the last chunk.
        msb_cin = s_ch[CHUNK_WIDTH-1] ^ a_ch[CHUNK_WIDTH-1] ^ b_ch[CHUNK_WIDTH-1];
        psum_nx = (psum_q >> CHUNK_WIDTH)
                | (BIT_WIDTH'(s_ch) << (BIT_WIDTH - CHUNK_WIDTH));
    end

    // Next-state logic: accept a start in IDLE, step chunks in CALC, and commit on the last chunk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    a_d     = a_i;
                    b_d     = sub_i ? ~b_i : b_i;
                    carry_d = sub_i ^ carry_in_i;
                    psum_d  = '0;
                end
            end
            CALC: begin
                a_d     = a_q >> CHUNK_WIDTH;
                b_d     = b_q >> CHUNK_WIDTH;
                carry_d = c_ch;
                psum_d  = psum_nx;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sum_d   = psum_nx;
                    cout_d  = c_ch;
                    ovf_d   = msb_cin ^ c_ch;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset has priority and aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy_o      = (state_q == CALC);
    assign done_o      = done_q;
    assign sum_o       = sum_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;

endmodule
